// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream elastic FIFO.
// Holds the occupancy state encodings and the pointer-width helper.
package axis_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_state_e;

  // Pointers index DEPTH entries and wrap naturally because DEPTH is a power of two.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Beat storage for the elastic FIFO: one write port and one registered read port.
// A same-cycle write to the address being read is forwarded so that a new head is never stale.
module axis_fifo_ram
  import axis_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end
  end

endmodule

// File: rtl/axis_elastic_fifo.sv
// AXI-Stream elastic FIFO with fully registered ready/valid/payload outputs.
// Define AXIS_FIFO_LEVEL_EN to expose the level and almost_full outputs.
module axis_elastic_fifo
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int USER_WIDTH  = 1,
  parameter int DEPTH       = 4,
  parameter int ALMOST_FULL = DEPTH - 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready
`ifdef AXIS_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    almost_full
`endif
);

  localparam int PTR_W  = ptr_w(DEPTH);
  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int BEAT_W = 1 + USER_WIDTH + KEEP_W + DATA_WIDTH;

  if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("axis_elastic_fifo: DATA_WIDTH must be a multiple of 8");
  end
  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axis_elastic_fifo: DEPTH must be a power of two in 2..256");
  end
  if (ALMOST_FULL < 1 || ALMOST_FULL > DEPTH) begin : g_bad_almost_full
    $error("axis_elastic_fifo: ALMOST_FULL must be in 1..DEPTH");
  end

  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr_inc;
  logic [PTR_W-1:0]  rd_ptr_inc;
  logic              rd_en;
  logic [PTR_W-1:0]  rd_addr;
  logic [BEAT_W-1:0] wr_beat;
  logic [BEAT_W-1:0] rd_beat;
  occ_state_e        state;

  assign push       = s_axis_tvalid && s_axis_tready;
  assign pop        = m_axis_tvalid && m_axis_tready;
  assign wr_ptr_inc = wr_ptr + 1'b1;
  assign rd_ptr_inc = rd_ptr + 1'b1;

  // The RAM read register is the output payload: reload it with the next head on
  // every pop, or with the incoming beat when it lands in an empty FIFO.
  assign rd_en   = pop || (push && !m_axis_tvalid);
  assign rd_addr = pop ? rd_ptr_inc : rd_ptr;
  assign wr_beat = {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
  assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = rd_beat;

  axis_fifo_ram #(
    .WIDTH  (BEAT_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk     (aclk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_beat),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_beat)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr_inc;
      if (pop)  rd_ptr <= rd_ptr_inc;
    end
  end

  // Occupancy FSM; ready and valid are registered from the state being entered.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= EMPTY;
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          s_axis_tready <= 1'b1;
          m_axis_tvalid <= push;
          if (push) state <= PARTIAL;
        end
        PARTIAL: begin
          if (push && !pop && (wr_ptr_inc == rd_ptr)) begin
            state         <= FULL;
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b1;
          end else if (pop && !push && (rd_ptr_inc == wr_ptr)) begin
            state         <= EMPTY;
            s_axis_tready <= 1'b1;
            m_axis_tvalid <= 1'b0;
          end else begin
            s_axis_tready <= 1'b1;
            m_axis_tvalid <= 1'b1;
          end
        end
        FULL: begin
          m_axis_tvalid <= 1'b1;
          s_axis_tready <= pop;
          if (pop) state <= PARTIAL;
        end
        default: begin
          state         <= EMPTY;
          s_axis_tready <= 1'b1;
          m_axis_tvalid <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXIS_FIFO_LEVEL_EN
  localparam logic [PTR_W:0] AF_LEVEL = (PTR_W + 1)'(ALMOST_FULL);

  logic [PTR_W:0] level_nxt;

  always_comb begin
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + 1'b1;
    end else if (pop && !push) begin
      level_nxt = level - 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      level       <= '0;
      almost_full <= 1'b0;
    end else begin
      level       <= level_nxt;
      almost_full <= (level_nxt >= AF_LEVEL);
    end
  end
`endif

endmodule

// File: tb/tb_axis_elastic_fifo.sv
// Self-checking bench for axis_elastic_fifo: directed scenarios plus randomized traffic
// compared every cycle against a queue-based model of the FIFO.
module tb_axis_elastic_fifo;

  localparam int DATA_W = 32;
  localparam int USER_W = 1;
  localparam int DEPTH  = 4;
  localparam int KEEP_W = DATA_W / 8;
  localparam int BW     = 1 + USER_W + KEEP_W + DATA_W;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic [KEEP_W-1:0] s_axis_tkeep = '0;
  logic [USER_W-1:0] s_axis_tuser = '0;
  logic              s_axis_tlast = 1'b0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [KEEP_W-1:0] m_axis_tkeep;
  logic [USER_W-1:0] m_axis_tuser;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
`ifdef AXIS_FIFO_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
  logic                   almost_full;
`endif

  axis_elastic_fifo #(
    .DATA_WIDTH (DATA_W),
    .USER_WIDTH (USER_W),
    .DEPTH      (DEPTH)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
`ifdef AXIS_FIFO_LEVEL_EN
    ,
    .level         (level),
    .almost_full   (almost_full)
`endif
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the FIFO is an ordered queue of beats; ready means "not full
  // and out of reset", valid means "not empty", and the head is what m_axis shows.
  logic [BW-1:0] q[$];
  bit            live = 1'b0;

  function automatic logic model_ready();
    return live && (q.size() < DEPTH);
  endfunction

  function automatic logic model_valid();
    return q.size() > 0;
  endfunction

  initial begin
    forever begin
      @(posedge aclk or negedge aresetn);
      if (!aresetn) begin
        q.delete();
        live = 1'b0;
      end else begin
        logic do_push, do_pop;
        do_push = s_axis_tvalid && model_ready();
        do_pop  = model_valid() && m_axis_tready;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back({s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata});
        live = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge aclk);
      chk("s_tready", 64'(s_axis_tready), 64'(model_ready()));
      chk("m_tvalid", 64'(m_axis_tvalid), 64'(model_valid()));
      if (model_valid())
        chk("m_payload", 64'({m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata}), 64'(q[0]));
`ifdef AXIS_FIFO_LEVEL_EN
      chk("level", 64'(level), 64'(q.size()));
      chk("almost_full", 64'(almost_full), 64'(q.size() >= DEPTH - 1));
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge aclk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k,
                       input logic [USER_W-1:0] u, input logic l);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
  endtask

  initial begin
    int                pushed;
    logic [DATA_W-1:0] cur_d;
    logic [KEEP_W-1:0] cur_k;
    logic [USER_W-1:0] cur_u;
    logic              cur_l;

    // Reset state
    repeat (3) tick();
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    aresetn = 1'b1;
    #1;
    chk("rel_tready_before_edge", 64'(s_axis_tready), 64'd0);
    tick();
    chk("rel_tready_first_edge", 64'(s_axis_tready), 64'd1);

    // Four beats straight through, one cycle latency each
    m_axis_tready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, DATA_W'(i), '1, '0, (i == 4));
      tick();
      chk("pass_tvalid", 64'(m_axis_tvalid), 64'd1);
      chk("pass_tdata", 64'(m_axis_tdata), 64'(i));
      chk("pass_tlast", 64'(m_axis_tlast), 64'(i == 4));
    end
    drive(1'b0, '0, '0, '0, 1'b0);
    tick();
    chk("pass_drained", 64'(m_axis_tvalid), 64'd0);

    // Fill to FULL with the sink stalled
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, DATA_W'(i), '1, '0, 1'b0);
      tick();
    end
    chk("full_tready", 64'(s_axis_tready), 64'd0);
    chk("full_head", 64'(m_axis_tdata), 64'd1);
`ifdef AXIS_FIFO_LEVEL_EN
    chk("full_level", 64'(level), 64'd4);
    chk("full_almost_full", 64'(almost_full), 64'd1);
`endif
    drive(1'b1, DATA_W'(5), '1, '0, 1'b0);
    tick();
    chk("full_5th_refused", 64'(s_axis_tready), 64'd0);
    chk("full_head_stable", 64'(m_axis_tdata), 64'd1);

    // One pop from FULL reopens the input on the following cycle
    m_axis_tready = 1'b1;
    tick();
    chk("unfull_tready", 64'(s_axis_tready), 64'd1);
    chk("unfull_head", 64'(m_axis_tdata), 64'd2);
    m_axis_tready = 1'b0;
    tick();
    chk("refull_tready", 64'(s_axis_tready), 64'd0);
    drive(1'b0, '0, '0, '0, 1'b0);
    m_axis_tready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("order_tdata", 64'(m_axis_tdata), 64'(i));
      tick();
    end
    chk("order_drained", 64'(m_axis_tvalid), 64'd0);

    // Simultaneous push and pop at level 1
    m_axis_tready = 1'b0;
    drive(1'b1, DATA_W'(32'h55), '1, '0, 1'b0);
    tick();
    chk("lvl1_head", 64'(m_axis_tdata), 64'h55);
    drive(1'b1, DATA_W'(32'hAA), '1, '0, 1'b0);
    m_axis_tready = 1'b1;
    tick();
    chk("swap_tdata", 64'(m_axis_tdata), 64'hAA);
    chk("swap_tvalid", 64'(m_axis_tvalid), 64'd1);
`ifdef AXIS_FIFO_LEVEL_EN
    chk("swap_level", 64'(level), 64'd1);
`endif
    drive(1'b0, '0, '0, '0, 1'b0);
    tick();
    chk("swap_drained", 64'(m_axis_tvalid), 64'd0);

    // Reset in the middle of a packet
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, DATA_W'(32'h10 + i), '1, '0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, '0, 1'b0);
    aresetn = 1'b0;
    #1;
    chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("midrst_tready", 64'(s_axis_tready), 64'd0);
    tick();
    tick();
    aresetn = 1'b1;
    tick();
    chk("postrst_tready", 64'(s_axis_tready), 64'd1);
    chk("postrst_tvalid", 64'(m_axis_tvalid), 64'd0);
`ifdef AXIS_FIFO_LEVEL_EN
    chk("postrst_level", 64'(level), 64'd0);
`endif
    m_axis_tready = 1'b1;
    repeat (3) tick();
    chk("no_stale_beat", 64'(m_axis_tvalid), 64'd0);

    // Randomized traffic
    pushed = 0;
    cur_d  = $urandom;
    cur_k  = KEEP_W'($urandom_range(0, (1 << KEEP_W) - 1));
    cur_u  = USER_W'($urandom_range(0, (1 << USER_W) - 1));
    cur_l  = ($urandom_range(0, 7) == 0);
    for (int cyc = 0; cyc < 20000 && pushed < 1000; cyc++) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        drive(1'b1, cur_d, cur_k, cur_u, cur_l);
        if (s_axis_tready) begin
          pushed++;
          cur_d = $urandom;
          cur_k = KEEP_W'($urandom_range(0, (1 << KEEP_W) - 1));
          cur_u = USER_W'($urandom_range(0, (1 << USER_W) - 1));
          cur_l = ($urandom_range(0, 7) == 0);
        end
      end else begin
        drive(1'b0, $urandom, KEEP_W'($urandom), USER_W'($urandom), 1'($urandom));
      end
      tick();
    end
    chk("rand_beats_pushed", 64'(pushed), 64'd1000);
    drive(1'b0, '0, '0, '0, 1'b0);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 50 && m_axis_tvalid; i++) tick();
    chk("rand_drained", 64'(m_axis_tvalid), 64'd0);
    chk("rand_model_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
